// File: rtl/hex_display_driver_pkg.sv
// Segment definitions shared by the hex display front end: bit positions,
// the sixteen hex glyphs in {g,f,e,d,c,b,a} order, and the blank pattern.
package hex_display_driver_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/hex_display_driver_hex_to_seg.sv
// Combinational nibble-to-glyph decoder; one instance per displayed digit.
module hex_to_seg
   import hex_display_driver_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      unique case (nibble_i)
         4'h0: seg_o = GLYPH_0;
         4'h1: seg_o = GLYPH_1;
         4'h2: seg_o = GLYPH_2;
         4'h3: seg_o = GLYPH_3;
         4'h4: seg_o = GLYPH_4;
         4'h5: seg_o = GLYPH_5;
         4'h6: seg_o = GLYPH_6;
         4'h7: seg_o = GLYPH_7;
         4'h8: seg_o = GLYPH_8;
         4'h9: seg_o = GLYPH_9;
         4'hA: seg_o = GLYPH_A;
         4'hB: seg_o = GLYPH_B;
         4'hC: seg_o = GLYPH_C;
         4'hD: seg_o = GLYPH_D;
         4'hE: seg_o = GLYPH_E;
         4'hF: seg_o = GLYPH_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_display_driver.sv
// Two-digit hex display front end: refresh toggle, frame-aligned value update,
// leading-zero blanking, blinking and registered segment outputs.
module hex_display_driver
   import hex_display_driver_pkg::*;
#(
   parameter int REFRESH_DIV  = 12000,
   parameter int BLINK_FRAMES = 64,
   parameter bit SEG_INVERT   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] value,
   input  logic       load,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic       dividedClk,
   output logic [6:0] disp0,
   output logic [6:0] disp1,
   output logic       updated
);

   localparam int CW  = $clog2(REFRESH_DIV);
   localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [6:0] INV_MASK = SEG_INVERT ? 7'h7F : 7'h00;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic           div_q, div_d;
   logic [7:0]     pend_q, pend_d;
   logic           pend_vld_q, pend_vld_d;
   logic [7:0]     shown_q, shown_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic           phase_q, phase_d;
   logic           upd_q, upd_d;
   logic [6:0]     disp0_q, disp0_d;
   logic [6:0]     disp1_q, disp1_d;

   logic           wrap, frame_end, apply;
   logic [6:0]     glyph_lo, glyph_hi;

   hex_to_seg u_seg_lo (.nibble_i(shown_q[3:0]), .seg_o(glyph_lo));
   hex_to_seg u_seg_hi (.nibble_i(shown_q[7:4]), .seg_o(glyph_hi));

   assign wrap      = (cnt_q == CW'(REFRESH_DIV - 1));
   assign frame_end = wrap && div_q;
   assign apply     = frame_end && pend_vld_q;

   always_comb begin
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      div_d      = wrap ? ~div_q : div_q;

      // A load on the apply cycle still wins: the old pending is applied and
      // the new one stays queued for the next frame.
      pend_d     = load ? value : pend_q;
      pend_vld_d = load ? 1'b1 : (apply ? 1'b0 : pend_vld_q);
      shown_d    = apply ? pend_q : shown_q;
      upd_d      = apply;

      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      if (!blink_en) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (frame_end) begin
         if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d  = bcnt_q + 1'b1;
         end
      end

      disp0_d = (phase_q ? SEG_BLANK : glyph_lo) ^ INV_MASK;
      disp1_d = ((phase_q || (blank_lz && shown_q[7:4] == 4'h0)) ? SEG_BLANK : glyph_hi) ^ INV_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         div_q      <= 1'b0;
         pend_q     <= 8'h00;
         pend_vld_q <= 1'b0;
         shown_q    <= 8'h00;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         upd_q      <= 1'b0;
         disp0_q    <= SEG_BLANK ^ INV_MASK;
         disp1_q    <= SEG_BLANK ^ INV_MASK;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         shown_q    <= shown_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         upd_q      <= upd_d;
         disp0_q    <= disp0_d;
         disp1_q    <= disp1_d;
      end
   end

   assign dividedClk = div_q;
   assign disp0      = disp0_q;
   assign disp1      = disp1_q;
   assign updated    = upd_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: a cycle-count based reference model drives
// expectations for a normal and an inverted-segment instance in lockstep.
module tb_hex_display_driver;

   localparam int RD = 4;
   localparam int BF = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] value = 8'h00;
   logic       load = 1'b0;
   logic       blank_lz = 1'b0;
   logic       blink_en = 1'b0;

   logic       dclk_a, upd_a, dclk_b, upd_b;
   logic [6:0] d0_a, d1_a, d0_b, d1_b;

   int n_cmp = 0;
   int n_err = 0;

   hex_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .SEG_INVERT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
      .blink_en(blink_en), .dividedClk(dclk_a), .disp0(d0_a), .disp1(d1_a), .updated(upd_a));

   hex_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .SEG_INVERT(1'b1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
      .blink_en(blink_en), .dividedClk(dclk_b), .disp0(d0_b), .disp1(d1_b), .updated(upd_b));

   always #5 clk = ~clk;

   // Reference model: time is a cycle count since reset; blink phase is the
   // parity of whole blink periods elapsed while blink_en stayed high.
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int         m_n;
   int         m_frames;
   logic [7:0] m_pend, m_shown;
   logic       m_pv, m_upd;
   logic [6:0] m_d0, m_d1;

   function automatic logic m_phase();
      return ((m_frames / BF) % 2) == 1;
   endfunction

   task automatic model_reset();
      m_n = 0; m_frames = 0; m_pend = 8'h00; m_shown = 8'h00;
      m_pv = 1'b0; m_upd = 1'b0; m_d0 = 7'h00; m_d1 = 7'h00;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic dexp;
      dexp = ((m_n / RD) % 2) == 1;
      chk("divclk",     {7'b0, dclk_a}, {7'b0, dexp});
      chk("updated",    {7'b0, upd_a},  {7'b0, m_upd});
      chk("disp0",      {1'b0, d0_a},   {1'b0, m_d0});
      chk("disp1",      {1'b0, d1_a},   {1'b0, m_d1});
      chk("inv_divclk", {7'b0, dclk_b}, {7'b0, dexp});
      chk("inv_disp0",  {1'b0, d0_b},   {1'b0, ~m_d0});
      chk("inv_disp1",  {1'b0, d1_b},   {1'b0, ~m_d1});
   endtask

   // One clock: model takes the inputs seen at this edge, then outputs are checked.
   task automatic tick();
      logic       fe, ph;
      logic [6:0] n_d0, n_d1;
      fe = (m_n % (2 * RD)) == (2 * RD - 1);
      ph = m_phase();
      n_d0 = ph ? 7'h00 : glyph[m_shown[3:0]];
      n_d1 = (ph || (blank_lz && m_shown[7:4] == 4'h0)) ? 7'h00 : glyph[m_shown[7:4]];
      @(posedge clk);
      if (rst_n) begin
         m_d0 = n_d0;
         m_d1 = n_d1;
         m_upd = fe && m_pv;
         if (fe && m_pv) m_shown = m_pend;
         if (load) begin
            m_pend = value;
            m_pv = 1'b1;
         end else if (fe) begin
            m_pv = 1'b0;
         end
         m_frames = blink_en ? m_frames + (fe ? 1 : 0) : 0;
         m_n++;
      end
      #1;
      check_all();
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic do_load(input logic [7:0] v);
      value = v; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Advance so the next tick's edge is a frame end.
   task automatic to_frame_end();
      while ((m_n % (2 * RD)) != (2 * RD - 1)) tick();
   endtask

   initial begin
      model_reset();
      #12;
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(20);

      // Async reset mid-count, with a pending load outstanding.
      do_load(8'h99);
      run(2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      rst_n = 1'b1;
      run(18);

      // Single load held until frame end.
      do_load(8'hA5);
      run(2 * RD + 3);
      chk("a5_disp1", {1'b0, d1_a}, 8'h77);
      chk("a5_disp0", {1'b0, d0_a}, 8'h6D);

      // Last load before a frame end wins.
      do_load(8'h12);
      do_load(8'h3F);
      run(2 * RD + 3);

      // Load coinciding with frame end.
      do_load(8'h42);
      to_frame_end();
      do_load(8'hC3);
      run(2 * RD + 2);

      // Leading-zero blanking.
      blank_lz = 1'b1;
      do_load(8'h07);
      run(2 * RD + 2);
      chk("lz_disp1", {1'b0, d1_a}, 8'h00);
      blank_lz = 1'b0;
      run(2);
      blank_lz = 1'b1;
      do_load(8'h00);
      run(2 * RD + 2);
      blank_lz = 1'b0;

      // Blinking, then disable during a blank half-period.
      do_load(8'h5F);
      run(2 * RD + 2);
      blink_en = 1'b1;
      run(2 * RD * BF * 3);
      while (!m_phase()) tick();
      run(3);
      blink_en = 1'b0;
      run(4);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         load = ($urandom_range(0, 9) == 0);
         value = 8'($urandom);
         if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 79) == 0) blink_en = ~blink_en;
         if ($urandom_range(0, 399) == 0) begin
            load = 1'b0;
            #3 rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      load = 1'b0;
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
